// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES-128 definitions for the iterative encryption core:
//   NUM_ROUNDS  - AES-128 round count (fixed at 10)
//   aes_state_e - control FSM states of aes_encrypt_iter
//   SBOX        - forward S-box, entry i is SubBytes(i)
//   xtime       - multiply by x (0x02) in GF(2^8) modulo x^8+x^4+x^3+x+1
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam int NUM_ROUNDS = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } aes_state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Multiply by 0x02 in GF(2^8); 0x1b folds the x^8 term back in.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_enc_round.sv
// ---------------------------------------------------------------------------
// aes_enc_round
// One AES encryption round, purely combinational.
//   state_i     [127:0]  current state, byte 0 = bits [127:120], column-major
//   round_key_i [127:0]  round key for this round, same byte order
//   last_i               final round: MixColumns is skipped
//   state_o     [127:0]  next state
// ---------------------------------------------------------------------------
module aes_enc_round
    import aes_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] round_key_i,
    input  logic         last_i,
    output logic [127:0] state_o
);

    logic [7:0] sb [16];   // after SubBytes
    logic [7:0] sr [16];   // after ShiftRows
    logic [7:0] mc [16];   // after MixColumns

    genvar gi;

    // SubBytes and ShiftRows. Byte index is row + 4*col; row r rotates
    // left by r columns, so output (r,c) takes input (r, (c+r) mod 4).
    generate
        for (gi = 0; gi < 16; gi++) begin : gen_sub_shift
            assign sb[gi] = SBOX[state_i[127-8*gi -: 8]];
            assign sr[gi] = sb[(gi % 4) + 4 * (((gi / 4) + (gi % 4)) % 4)];
        end
    endgenerate

    // MixColumns: each column multiplied by the circulant {02,03,01,01}.
    // 03*a is formed as xtime(a)^a.
    generate
        for (gi = 0; gi < 4; gi++) begin : gen_mix
            logic [7:0] a0, a1, a2, a3;
            assign a0 = sr[4*gi + 0];
            assign a1 = sr[4*gi + 1];
            assign a2 = sr[4*gi + 2];
            assign a3 = sr[4*gi + 3];
            assign mc[4*gi + 0] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            assign mc[4*gi + 1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            assign mc[4*gi + 2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            assign mc[4*gi + 3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
    endgenerate

    // AddRoundKey on either the mixed or the unmixed (last round) bytes.
    generate
        for (gi = 0; gi < 16; gi++) begin : gen_ark
            assign state_o[127-8*gi -: 8] = (last_i ? sr[gi] : mc[gi]) ^ round_key_i[127-8*gi -: 8];
        end
    endgenerate

endmodule

// File: rtl/aes_encrypt_iter.sv
// ---------------------------------------------------------------------------
// aes_encrypt_iter
// Iterative AES-128 encryption: one round per clock through a single shared
// round datapath, one block per 11 clocks with the output handshake
// overlapping the next acceptance.
//   clk                 system clock, rising edge
//   n_rst               asynchronous active-low reset
//   key        [1407:0] expanded key, round key i = key[128*i +: 128]
//   in_valid / in_ready handshake for plain_in
//   plain_in   [127:0]  plaintext, byte 0 = bits [127:120], column-major
//   out_valid / out_ready handshake for cipher_out
//   cipher_out [127:0]  ciphertext, meaningful only while out_valid=1
// ---------------------------------------------------------------------------
module aes_encrypt_iter
    import aes_pkg::*;
(
    input  logic          clk,
    input  logic          n_rst,
    input  logic [1407:0] key,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [127:0]  plain_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [127:0]  cipher_out
);

    aes_state_e   fsm_q;
    logic [127:0] state_q;
    logic [3:0]   rnd_q;

    logic [127:0] rk [NUM_ROUNDS+1];
    logic [127:0] rk_sel;
    logic [127:0] round_out;
    logic         last_round;

    genvar gi;

    generate
        for (gi = 0; gi <= NUM_ROUNDS; gi++) begin : gen_rk
            assign rk[gi] = key[128*gi +: 128];
        end
    endgenerate

    // Round-key mux for rounds 1..10; rk[0] is only used on block load.
    always_comb begin
        rk_sel = '0;
        for (int i = 1; i <= NUM_ROUNDS; i++) begin
            if (rnd_q == 4'(i)) begin
                rk_sel = rk[i];
            end
        end
    end

    assign last_round = (rnd_q == 4'(NUM_ROUNDS));

    aes_enc_round u_round (
        .state_i     (state_q),
        .round_key_i (rk_sel),
        .last_i      (last_round),
        .state_o     (round_out)
    );

    // In DONE the output and input handshakes share an edge, so the core
    // can take a new block exactly when the finished one is taken.
    assign in_ready   = (fsm_q == IDLE) || ((fsm_q == DONE) && out_ready);
    assign out_valid  = (fsm_q == DONE);
    assign cipher_out = state_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            rnd_q   <= '0;
        end else begin
            unique case (fsm_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q <= plain_in ^ rk[0];
                        rnd_q   <= 4'd1;
                        fsm_q   <= ROUND;
                    end
                end
                ROUND: begin
                    state_q <= round_out;
                    if (last_round) begin
                        fsm_q <= DONE;
                    end else begin
                        rnd_q <= rnd_q + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            state_q <= plain_in ^ rk[0];
                            rnd_q   <= 4'd1;
                            fsm_q   <= ROUND;
                        end else begin
                            fsm_q <= IDLE;
                        end
                    end
                end
                default: begin
                    fsm_q <= IDLE;
                end
            endcase
        end
    end

endmodule
